// File: rtl/brc_pkg.sv
// Shared types and helpers for the serial branch comparator.
// Optional early-exit build: define BRC_EARLY_EXIT_EN (see brc_serial_compare.sv).
package brc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } brc_state_e;

  localparam logic BR_SIGNED   = 1'b0;
  localparam logic BR_UNSIGNED = 1'b1;

  function automatic int unsigned ndig(input int unsigned data_w,
                                       input int unsigned digit_w);
    return data_w / digit_w;
  endfunction

endpackage

// File: rtl/brc_digit_cmp.sv
// Combinational unsigned compare of one operand digit.
module brc_digit_cmp #(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  output logic               lt_o,
  output logic               eq_o
);

  always_comb begin
    lt_o = (a_i < b_i);
    eq_o = (a_i == b_i);
  end

endmodule

// File: rtl/brc_serial_compare.sv
// Multi-cycle MSB-first branch comparator producing br_less / br_equal.
// Define BRC_EARLY_EXIT_EN to finish on the first unequal digit.
module brc_serial_compare
  import brc_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_br_un,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_br_less,
  output logic              o_br_equal,
  output logic              o_busy
);

  localparam int unsigned NDIG  = ndig(DATA_W, DIGIT_W);
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (DATA_W % DIGIT_W != 0) begin : g_bad_digit_w
    $error("brc_serial_compare: DATA_W must be a multiple of DIGIT_W");
  end

  brc_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]    a_q, a_d;
  logic [DATA_W-1:0]    b_q, b_d;
  logic                 decided_q, decided_d;
  logic                 lt_q, lt_d;

  logic [DATA_W-1:0]              bias;
  logic [NDIG-1:0][DIGIT_W-1:0]   a_v, b_v;
  logic                           dig_lt, dig_eq;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign bias = {(i_br_un == BR_SIGNED), {(DATA_W-1){1'b0}}};
  assign a_v  = a_q;
  assign b_v  = b_q;

  brc_digit_cmp #(.DIGIT_W(DIGIT_W)) u_digit_cmp (
    .a_i  (a_v[idx_q]),
    .b_i  (b_v[idx_q]),
    .lt_o (dig_lt),
    .eq_o (dig_eq)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    decided_d = decided_q;
    lt_d      = lt_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d   = SCAN;
          a_d       = i_a ^ bias;
          b_d       = i_b ^ bias;
          idx_d     = IDX_W'(NDIG - 1);
          decided_d = 1'b0;
          lt_d      = 1'b0;
        end
      end
      SCAN: begin
        idx_d = idx_q - IDX_W'(1);
        if (!decided_q && !dig_eq) begin
          decided_d = 1'b1;
          lt_d      = dig_lt;
        end
`ifdef BRC_EARLY_EXIT_EN
        if (idx_q == '0 || (!decided_q && !dig_eq)) state_d = DONE;
`else
        if (idx_q == '0) state_d = DONE;
`endif
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      decided_q <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      decided_q <= decided_d;
      lt_q      <= lt_d;
    end
  end

  always_comb begin
    o_ready    = (state_q == IDLE);
    o_busy     = (state_q != IDLE);
    o_valid    = (state_q == DONE);
    o_br_less  = (state_q == DONE) &  lt_q;
    o_br_equal = (state_q == DONE) & ~decided_q;
  end

endmodule
